// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the program counter, fetches words over a req/ack
// handshake into the instruction register and issues them to the microcoded controller.
module fetch_unit #(
   parameter int                PC_W     = 8,
   parameter int                INSTR_W  = 23,
   parameter logic [PC_W-1:0]   RESET_PC = {PC_W{1'b0}}
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 run,
   output logic                 imem_req,
   output logic [PC_W-1:0]      imem_addr,
   input  logic                 imem_ack,
   input  logic [INSTR_W-1:0]   imem_rdata,
   input  logic                 inc_pc,
   input  logic                 branch,
   input  logic [PC_W-1:0]      branch_target,
   output logic [INSTR_W-1:0]   code,
   output logic                 start,
   output logic [PC_W-1:0]      pc,
   output logic                 busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      ISSUE = 2'd2,
      EXEC  = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [PC_W-1:0]      pc_q, pc_d;
   logic [INSTR_W-1:0]   code_q, code_d;

   // Next-state logic; imem_rdata is only looked at under imem_ack so X cannot leak into code.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      code_d  = code_q;
      case (state_q)
         IDLE: begin
            if (run) begin
               state_d = FETCH;
            end else begin
               state_d = IDLE;
            end
         end
         FETCH: begin
            if (imem_ack) begin
               code_d  = imem_rdata;
               state_d = ISSUE;
            end else begin
               state_d = FETCH;
            end
         end
         ISSUE: begin
            state_d = EXEC;
         end
         EXEC: begin
            if (branch || inc_pc) begin
               if (branch) begin
                  pc_d = branch_target;
               end else begin
                  pc_d = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
               end
               if (run) begin
                  state_d = FETCH;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               state_d = EXEC;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         code_q  <= {INSTR_W{1'b0}};
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         code_q  <= code_d;
      end
   end

   assign imem_req  = (state_q == FETCH);
   assign imem_addr = pc_q;
   assign start     = (state_q == ISSUE);
   assign busy      = (state_q != IDLE);
   assign code      = code_q;
   assign pc        = pc_q;

endmodule
